frame_stream_generator: RTL and testbench
=========================================

FRAME_STREAM_GENERATOR -- requirements
Module: frame_stream_generator

Interface
REQ-001 SHALL provide parameter DATA_BYTES, default 2, egress bytes per beat (legal 1, 2, 4, 8).
REQ-002 SHALL provide parameter PAYLOAD_DEPTH, default 64, payload buffer bytes (power of 2, 16..2048).
REQ-003 SHALL provide port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide ports writedata in 8, write in 1, read in 1, chipselect in 1, address in 8, readdata out 8, forming an Avalon-MM slave.
REQ-006 SHALL provide ports egress_port_tdata out 8*DATA_BYTES, egress_port_tkeep out DATA_BYTES, egress_port_tlast out 1, egress_port_tvalid out 1, egress_port_tready in 1, forming an AXI-Stream master.

Function
REQ-007 Register map SHALL be: 0x00-0x05 dst MAC, 0x06-0x0B src MAC, 0x0C-0x0D length/type (0x0C sent first), 0x0E-0x0F payload length L (little-endian), 0x10 IFG cycles, 0x11 frame count N (0 = continuous), 0x12 control, 0x13 status R, 0x14 payload write port W, 0x18-0x1B checksum R (little-endian).
REQ-008 Control bits SHALL be: bit0 start/run, bit1 pattern mode, bit2 clear (self-clearing, resets buffer write pointer and checksum).
REQ-009 Status SHALL read bit0 busy (state != IDLE), bit1 buffer-full (write pointer wrapped since clear).
REQ-010 Reads SHALL return data one cycle after chipselect&&read; readdata SHALL be 0 otherwise and for unmapped addresses.
REQ-011 Writes to 0x00-0x11 and 0x14 while busy SHALL be ignored; control writes SHALL always be accepted.
REQ-012 Each write to 0x14 SHALL store a byte at the write pointer, then increment it modulo PAYLOAD_DEPTH.
REQ-013 A frame SHALL be 7 bytes 0xAA, 1 byte 0xAB, 6 dst, 6 src, 2 length/type, then Leff payload bytes, in that order.
REQ-014 Leff SHALL be min(L, PAYLOAD_DEPTH) in buffer mode and L in pattern mode.
REQ-015 Buffer mode payload byte i SHALL be buffer[i].
REQ-016 Pattern mode payload byte i SHALL be (F + i) mod 256, where F = low 8 bits of frames sent since start.
REQ-017 The first byte of each beat SHALL be on tdata[8*DATA_BYTES-1 -: 8], with later bytes in descending lanes.
REQ-018 tkeep SHALL mark valid lanes MSB-first; invalid lanes SHALL carry 0; only the tlast beat SHALL be partial.
REQ-019 tvalid, tdata, tkeep and tlast SHALL hold stable while tvalid && !tready; a beat SHALL advance only on tvalid && tready.
REQ-020 FSM states SHALL be IDLE, SEND, GAP.
REQ-021 IDLE -> SEND SHALL occur on the cycle after start=1 is observed.
REQ-022 SEND -> GAP SHALL occur on tlast acceptance when N==0 or frames remaining > 1; otherwise SEND -> IDLE and start SHALL clear to 0.
REQ-023 GAP SHALL deassert tvalid for exactly IFG cycles and then return to SEND; IFG=0 SHALL produce back-to-back frames with no bubble.
REQ-024 Clearing start during SEND SHALL complete the current frame and then enter IDLE; frames SHALL never be truncated.
REQ-025 Clearing start during GAP SHALL enter IDLE immediately.
REQ-026 Checksum SHALL be the 32-bit wrapping sum of payload bytes of the last completed frame, updated on tlast acceptance.
REQ-027 Beat and byte counters SHALL be 16 bits and handle L up to 65535 with no overflow.

Reset
REQ-028 Reset SHALL force: state IDLE; tvalid, tlast, tdata, tkeep, readdata = 0; all registers, pointers, checksum and counters = 0.
REQ-029 Reset asserted mid-frame SHALL drop tvalid asynchronously; no partial-frame resume SHALL occur.

Configuration
REQ-030 With FRAME_GEN_STATS_EN defined: 32-bit frames-sent (0x1C-0x1F) and stall-cycle (tvalid&&!tready, 0x20-0x23) counters SHALL exist, readable and cleared by control bit2.
REQ-031 Without FRAME_GEN_STATS_EN: 0x1C-0x23 SHALL read 0 and no counter logic SHALL be present.

Verification
REQ-032 DATA_BYTES=2, buffer mode, L=3, payload 11,22,33, N=1, tready=1: 13 beats, beat0 0xAAAA, beat3 0xAAAB, last beat 0x3300 with tkeep=2'b10, checksum 0x66, status busy=0 afterward.
REQ-033 Pattern mode, L=4, N=3, IFG=5: three frames; payloads 00010203, 01020304, 02030405; exactly 5 tvalid-low cycles between frames.
REQ-034 tready toggled by random 50% duty: data/tkeep/tlast stable whenever stalled, output byte stream identical to REQ-032.
REQ-035 N=0, clear start mid-frame at beat 6: frame completes through tlast, then IDLE; write dst MAC while busy, readback unchanged.
REQ-036 L=100 in buffer mode with PAYLOAD_DEPTH=64: 64 payload bytes sent; reset asserted at beat 5: tvalid=0 same cycle, all registers read 0.

Source files
------------

// File: rtl/frame_stream_generator.sv
// Avalon-MM configured frame source: preamble/SFD, MAC header, then buffer or pattern payload on AXI-Stream.
// Define FRAME_GEN_STATS_EN to add frames-sent and stall-cycle counters at 0x1C-0x23.
module frame_stream_generator #(
    parameter int unsigned DATA_BYTES    = 2,
    parameter int unsigned PAYLOAD_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              writedata,
    input  logic                    write,
    input  logic                    read,
    input  logic                    chipselect,
    input  logic [7:0]              address,
    output logic [7:0]              readdata,
    output logic [8*DATA_BYTES-1:0] egress_port_tdata,
    output logic [DATA_BYTES-1:0]   egress_port_tkeep,
    output logic                    egress_port_tlast,
    output logic                    egress_port_tvalid,
    input  logic                    egress_port_tready
);
    localparam int unsigned PtrW     = $clog2(PAYLOAD_DEPTH);
    localparam int unsigned HdrBytes = 22;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          state_q, state_d;
    logic [7:0]      hdr_q [14];
    logic [15:0]     len_q;
    logic [7:0]      ifg_q, nframes_q;
    logic            pattern_q;
    logic            start_q, start_d;
    logic [PtrW-1:0] wr_ptr_q;
    logic            full_q;
    logic [7:0]      buf_q [PAYLOAD_DEPTH];
    logic [4:0]      hdr_cnt_q, hdr_cnt_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]      frame_idx_q, frame_idx_d;
    logic [7:0]      frames_left_q, frames_left_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            pat_act_q, pat_act_d;
    logic [31:0]     sum_q, sum_d;
    logic [31:0]     csum_q, csum_d;
    logic [7:0]      readdata_q, rdata;

    logic                    wr_en, cfg_wr, ctrl_wr, clear, busy;
    logic [15:0]             leff;
    logic [16:0]             hdr_rem, hdr_take;
    logic                    beat_last, beat_fire;
    logic [8*DATA_BYTES-1:0] tdata_c;
    logic [DATA_BYTES-1:0]   tkeep_c;
    logic [31:0]             beat_sum;
    logic [4:0]              lane_hidx;
    logic [16:0]             lane_pidx;
    logic [7:0]              lane_byte;
    logic                    lane_keep;

    assign wr_en   = chipselect && write;
    assign busy    = (state_q != StIdle);
    assign cfg_wr  = wr_en && !busy;
    assign ctrl_wr = wr_en && (address == 8'h12);
    assign clear   = ctrl_wr && writedata[2];

    // Effective payload length is latched-mode dependent so it cannot move while a beat is stalled.
    assign leff      = (pat_act_q || len_q <= 16'(PAYLOAD_DEPTH)) ? len_q : 16'(PAYLOAD_DEPTH);
    assign hdr_rem   = 17'(HdrBytes) - 17'(hdr_cnt_q);
    assign hdr_take  = (hdr_rem < 17'(DATA_BYTES)) ? hdr_rem : 17'(DATA_BYTES);
    assign beat_last = (17'(byte_cnt_q) + 17'(DATA_BYTES)) >= (17'(leff) + hdr_rem);

    assign egress_port_tvalid = (state_q == StSend);
    assign egress_port_tdata  = egress_port_tvalid ? tdata_c : '0;
    assign egress_port_tkeep  = egress_port_tvalid ? tkeep_c : '0;
    assign egress_port_tlast  = egress_port_tvalid && beat_last;
    assign beat_fire          = egress_port_tvalid && egress_port_tready;
    assign readdata           = readdata_q;

    // Lane j carries stream byte (current position + j); lane 0 sits in the top byte.
    always_comb begin
        tdata_c   = '0;
        tkeep_c   = '0;
        beat_sum  = '0;
        lane_hidx = '0;
        lane_pidx = '0;
        lane_byte = '0;
        lane_keep = 1'b0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            lane_byte = '0;
            lane_keep = 1'b0;
            lane_hidx = hdr_cnt_q + 5'(j);
            lane_pidx = 17'(byte_cnt_q) + 17'(j) - hdr_rem;
            if (17'(j) < hdr_rem) begin
                lane_keep = 1'b1;
                if (lane_hidx < 5'd7) begin
                    lane_byte = 8'hAA;
                end else if (lane_hidx == 5'd7) begin
                    lane_byte = 8'hAB;
                end else begin
                    lane_byte = hdr_q[4'(lane_hidx - 5'd8)];
                end
            end else if (lane_pidx < 17'(leff)) begin
                lane_keep = 1'b1;
                lane_byte = pat_act_q ? (frame_idx_q + lane_pidx[7:0]) : buf_q[lane_pidx[PtrW-1:0]];
                beat_sum  = beat_sum + 32'(lane_byte);
            end
            tdata_c[8*(DATA_BYTES-j)-1 -: 8] = lane_byte;
            tkeep_c[DATA_BYTES-1-j]          = lane_keep;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 14; i++) hdr_q[i] <= '0;
            for (int i = 0; i < PAYLOAD_DEPTH; i++) buf_q[i] <= '0;
            len_q     <= '0;
            ifg_q     <= '0;
            nframes_q <= '0;
            pattern_q <= 1'b0;
            wr_ptr_q  <= '0;
            full_q    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                if (address < 8'd14) hdr_q[address[3:0]] <= writedata;
                case (address)
                    8'h0E:   len_q[7:0]  <= writedata;
                    8'h0F:   len_q[15:8] <= writedata;
                    8'h10:   ifg_q       <= writedata;
                    8'h11:   nframes_q   <= writedata;
                    8'h14: begin
                        buf_q[wr_ptr_q] <= writedata;
                        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
                        if (wr_ptr_q == PtrW'(PAYLOAD_DEPTH - 1)) full_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (ctrl_wr) pattern_q <= writedata[1];
            if (clear) begin
                wr_ptr_q <= '0;
                full_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            start_q       <= 1'b0;
            hdr_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            frame_idx_q   <= '0;
            frames_left_q <= '0;
            gap_cnt_q     <= '0;
            pat_act_q     <= 1'b0;
            sum_q         <= '0;
            csum_q        <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            hdr_cnt_q     <= hdr_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            frame_idx_q   <= frame_idx_d;
            frames_left_q <= frames_left_d;
            gap_cnt_q     <= gap_cnt_d;
            pat_act_q     <= pat_act_d;
            sum_q         <= sum_d;
            csum_q        <= csum_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        hdr_cnt_d     = hdr_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        frame_idx_d   = frame_idx_q;
        frames_left_d = frames_left_q;
        gap_cnt_d     = gap_cnt_q;
        pat_act_d     = pat_act_q;
        sum_d         = sum_q;
        csum_d        = csum_q;
        case (state_q)
            StIdle: begin
                if (start_q) begin
                    state_d       = StSend;
                    hdr_cnt_d     = '0;
                    byte_cnt_d    = '0;
                    sum_d         = '0;
                    frame_idx_d   = '0;
                    frames_left_d = nframes_q;
                    pat_act_d     = pattern_q;
                end
            end
            StSend: begin
                if (beat_fire && beat_last) begin
                    hdr_cnt_d     = '0;
                    byte_cnt_d    = '0;
                    sum_d         = '0;
                    csum_d        = sum_q + beat_sum;
                    frame_idx_d   = frame_idx_q + 8'd1;
                    frames_left_d = frames_left_q - 8'd1;
                    if (!start_q) begin
                        state_d = StIdle;
                    end else if (nframes_q == 8'd0 || frames_left_q > 8'd1) begin
                        pat_act_d = pattern_q;
                        gap_cnt_d = '0;
                        state_d   = (ifg_q == 8'd0) ? StSend : StGap;
                    end else begin
                        state_d = StIdle;
                        start_d = 1'b0;
                    end
                end else if (beat_fire) begin
                    hdr_cnt_d  = hdr_cnt_q + 5'(hdr_take);
                    byte_cnt_d = byte_cnt_q + 16'(17'(DATA_BYTES) - hdr_take);
                    sum_d      = sum_q + beat_sum;
                end
            end
            StGap: begin
                if (!start_q) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == ifg_q - 8'd1) begin
                    state_d   = StSend;
                    pat_act_d = pattern_q;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ctrl_wr) start_d = writedata[0];
        if (clear) csum_d = '0;
    end

`ifdef FRAME_GEN_STATS_EN
    logic [31:0] frames_sent_q, stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_sent_q <= '0;
            stall_cnt_q   <= '0;
        end else if (clear) begin
            frames_sent_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (beat_fire && beat_last) frames_sent_q <= frames_sent_q + 32'd1;
            if (egress_port_tvalid && !egress_port_tready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (address < 8'd14) begin
            rdata = hdr_q[address[3:0]];
        end else begin
            case (address)
                8'h0E:   rdata = len_q[7:0];
                8'h0F:   rdata = len_q[15:8];
                8'h10:   rdata = ifg_q;
                8'h11:   rdata = nframes_q;
                8'h12:   rdata = {6'b0, pattern_q, start_q};
                8'h13:   rdata = {6'b0, full_q, busy};
                8'h18:   rdata = csum_q[7:0];
                8'h19:   rdata = csum_q[15:8];
                8'h1A:   rdata = csum_q[23:16];
                8'h1B:   rdata = csum_q[31:24];
`ifdef FRAME_GEN_STATS_EN
                8'h1C:   rdata = frames_sent_q[7:0];
                8'h1D:   rdata = frames_sent_q[15:8];
                8'h1E:   rdata = frames_sent_q[23:16];
                8'h1F:   rdata = frames_sent_q[31:24];
                8'h20:   rdata = stall_cnt_q[7:0];
                8'h21:   rdata = stall_cnt_q[15:8];
                8'h22:   rdata = stall_cnt_q[23:16];
                8'h23:   rdata = stall_cnt_q[31:24];
`endif
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= (chipselect && read) ? rdata : 8'h00;
        end
    end

endmodule

// File: tb/tb_frame_stream_generator.sv
// Directed self-checking bench for frame_stream_generator (DATA_BYTES=2, PAYLOAD_DEPTH=64).
`timescale 1ns/1ps
module tb_frame_stream_generator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  writedata = '0;
    logic [7:0]  address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        chipselect = 1'b0;
    logic [7:0]  readdata;
    logic [15:0] tdata;
    logic [1:0]  tkeep;
    logic        tlast, tvalid;
    logic        tready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_hdr [22];
    logic [7:0]  cap_bytes [$];
    logic [15:0] cap_data [$];
    logic [1:0]  cap_keep [$];
    logic        cap_last [$];
    int          gaps [$];
    int          stall_viol, lane_viol;
    bit          cap_done;

    always #5 clk = ~clk;

    frame_stream_generator #(
        .DATA_BYTES    (2),
        .PAYLOAD_DEPTH (64)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .writedata          (writedata),
        .write              (write),
        .read               (read),
        .chipselect         (chipselect),
        .address            (address),
        .readdata           (readdata),
        .egress_port_tdata  (tdata),
        .egress_port_tkeep  (tkeep),
        .egress_port_tlast  (tlast),
        .egress_port_tvalid (tvalid),
        .egress_port_tready (tready)
    );

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic program_header();
        for (int i = 0; i < 12; i++) bus_write(8'(i), 8'(i + 1));
        bus_write(8'h0C, 8'h08);
        bus_write(8'h0D, 8'h00);
    endtask

    // Collects accepted beats; tready is chosen before the beat is observed each cycle.
    task automatic capture(input int n_frames, input bit rnd, input int budget);
        int          frames = 0;
        int          cyc = 0;
        int          gap = 0;
        bit          in_gap = 1'b0;
        bit          pstall = 1'b0;
        logic [15:0] pd = '0;
        logic [1:0]  pk = '0;
        logic        pl = 1'b0;
        cap_bytes.delete(); cap_data.delete(); cap_keep.delete(); cap_last.delete();
        gaps.delete();
        stall_viol = 0; lane_viol = 0;
        while (frames < n_frames && cyc < budget) begin
            @(negedge clk);
            cyc++;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pstall && (!tvalid || tdata !== pd || tkeep !== pk || tlast !== pl)) stall_viol++;
            if (tvalid) begin
                if (in_gap) begin
                    gaps.push_back(gap);
                    in_gap = 1'b0;
                end
                if (tready) begin
                    cap_data.push_back(tdata);
                    cap_keep.push_back(tkeep);
                    cap_last.push_back(tlast);
                    for (int j = 0; j < 2; j++) begin
                        if (tkeep[1-j]) cap_bytes.push_back(tdata[15-8*j -: 8]);
                        else if (tdata[15-8*j -: 8] !== 8'h00) lane_viol++;
                    end
                    if (tlast) begin
                        frames++;
                        in_gap = 1'b1;
                        gap = 0;
                    end
                end
                pstall = !tready;
                pd = tdata; pk = tkeep; pl = tlast;
            end else begin
                pstall = 1'b0;
                if (in_gap) gap++;
            end
        end
        tready = 1'b1;
        cap_done = (frames == n_frames);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b0 || tlast !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: tvalid=%b tlast=%b, want 0 0", tvalid, tlast);
        end
        n_tests++;
        if (tdata !== 16'h0 || tkeep !== 2'b00 || readdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: tdata=%h tkeep=%b readdata=%h, want 0", tdata, tkeep, readdata);
        end
        reset = 1'b0;
        bus_read(8'h13, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", d); end
        bus_read(8'h18, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_checksum: got %h want 00", d); end
    endtask

    task automatic test_buffer_frame();
        logic [7:0] d;
        logic [7:0] exp [$];
        int bad = 0;
        int partial = 0;
        int lasts = 0;
        program_header();
        bus_write(8'h0E, 8'd3);
        bus_write(8'h0F, 8'd0);
        bus_write(8'h10, 8'd0);
        bus_write(8'h11, 8'd1);
        bus_write(8'h12, 8'h04);
        bus_write(8'h14, 8'h11);
        bus_write(8'h14, 8'h22);
        bus_write(8'h14, 8'h33);
        bus_read(8'h00, d);
        n_tests++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL dst0_readback: got %h want 01", d); end
        @(negedge clk);
        n_tests++;
        if (readdata !== 8'h00) begin n_fail++; $display("FAIL readdata_idle: got %h want 00", readdata); end
        bus_read(8'h30, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h want 00", d); end
        bus_read(8'h1C, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL stats_absent: got %h want 00", d); end
        bus_read(8'h0E, d);
        n_tests++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL len_readback: got %h want 03", d); end

        bus_write(8'h12, 8'h01);
        capture(1, 1'b0, 200);
        n_tests++;
        if (!cap_done) begin n_fail++; $display("FAIL buf_timeout: got %0d beats, want tlast", cap_data.size()); end
        n_tests++;
        if (cap_data.size() !== 13) begin n_fail++; $display("FAIL buf_beats: got %0d want 13", cap_data.size()); end
        if (cap_data.size() == 13) begin
            n_tests++;
            if (cap_data[0] !== 16'hAAAA) begin n_fail++; $display("FAIL buf_beat0: got %h want AAAA", cap_data[0]); end
            n_tests++;
            if (cap_data[3] !== 16'hAAAB) begin n_fail++; $display("FAIL buf_beat3: got %h want AAAB", cap_data[3]); end
            n_tests++;
            if (cap_data[12] !== 16'h3300 || cap_keep[12] !== 2'b10) begin
                n_fail++;
                $display("FAIL buf_last: got %h/%b want 3300/10", cap_data[12], cap_keep[12]);
            end
            for (int i = 0; i < 13; i++) begin
                if (cap_last[i]) lasts++;
                if (i < 12 && cap_keep[i] !== 2'b11) partial++;
            end
            n_tests++;
            if (lasts !== 1 || cap_last[12] !== 1'b1 || partial !== 0) begin
                n_fail++;
                $display("FAIL buf_framing: tlast count %0d partial %0d, want 1 0", lasts, partial);
            end
        end
        for (int i = 0; i < 22; i++) exp.push_back(exp_hdr[i]);
        exp.push_back(8'h11); exp.push_back(8'h22); exp.push_back(8'h33);
        for (int i = 0; i < exp.size() && i < cap_bytes.size(); i++) if (cap_bytes[i] !== exp[i]) bad++;
        n_tests++;
        if (bad !== 0 || cap_bytes.size() !== exp.size() || lane_viol !== 0) begin
            n_fail++;
            $display("FAIL buf_bytes: %0d bad of %0d, lane errs %0d, want 0 of 25", bad, cap_bytes.size(), lane_viol);
        end
        bus_read(8'h18, d);
        n_tests++;
        if (d !== 8'h66) begin n_fail++; $display("FAIL buf_checksum: got %h want 66", d); end
        bus_read(8'h13, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL buf_status: got %h want 00", d); end
        bus_read(8'h12, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL buf_start_clr: got %h want 00", d); end
    endtask

    task automatic test_pattern();
        logic [7:0] d;
        int bad = 0;
        bus_write(8'h0E, 8'd4);
        bus_write(8'h11, 8'd3);
        bus_write(8'h10, 8'd5);
        bus_write(8'h12, 8'h03);
        capture(3, 1'b0, 400);
        n_tests++;
        if (!cap_done || cap_bytes.size() !== 78) begin
            n_fail++; $display("FAIL pat_len: done=%0d bytes=%0d want 1 78", cap_done, cap_bytes.size());
        end
        if (cap_bytes.size() == 78) begin
            for (int f = 0; f < 3; f++)
                for (int i = 0; i < 4; i++)
                    if (cap_bytes[26*f + 22 + i] !== 8'(f + i)) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL pat_payload: %0d bad bytes want 0", bad); end
        n_tests++;
        if (gaps.size() !== 2) begin
            n_fail++; $display("FAIL pat_gapcount: got %0d gaps want 2", gaps.size());
        end else if (gaps[0] !== 5 || gaps[1] !== 5) begin
            n_fail++; $display("FAIL pat_ifg: got %0d,%0d want 5,5", gaps[0], gaps[1]);
        end
        bus_read(8'h18, d);
        n_tests++;
        if (d !== 8'h0E) begin n_fail++; $display("FAIL pat_checksum: got %h want 0E", d); end
        bus_read(8'h13, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL pat_status: got %h want 00", d); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        logic [7:0] exp [$];
        int bad = 0;
        bus_write(8'h0E, 8'd3);
        bus_write(8'h11, 8'd1);
        bus_write(8'h10, 8'd0);
        bus_write(8'h12, 8'h01);
        capture(1, 1'b1, 600);
        n_tests++;
        if (!cap_done || cap_data.size() !== 13) begin
            n_fail++; $display("FAIL bp_beats: done=%0d beats=%0d want 1 13", cap_done, cap_data.size());
        end
        n_tests++;
        if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_viol); end
        for (int i = 0; i < 22; i++) exp.push_back(exp_hdr[i]);
        exp.push_back(8'h11); exp.push_back(8'h22); exp.push_back(8'h33);
        for (int i = 0; i < exp.size() && i < cap_bytes.size(); i++) if (cap_bytes[i] !== exp[i]) bad++;
        n_tests++;
        if (bad !== 0 || cap_bytes.size() !== exp.size()) begin
            n_fail++; $display("FAIL bp_bytes: %0d bad of %0d want 0 of 25", bad, cap_bytes.size());
        end
        bus_read(8'h18, d);
        n_tests++;
        if (d !== 8'h66) begin n_fail++; $display("FAIL bp_checksum: got %h want 66", d); end
    endtask

    task automatic test_stop_mid_frame();
        logic [7:0] d;
        int  beats = 0;
        int  cyc = 0;
        int  extra = 0;
        bit  seen_last = 1'b0;
        bus_write(8'h11, 8'd0);
        bus_write(8'h12, 8'h01);
        while (!seen_last && cyc < 300) begin
            @(negedge clk);
            cyc++;
            chipselect = 1'b0; write = 1'b0;
            tready = 1'b1;
            if (tvalid) begin
                if (beats == 6) begin
                    chipselect = 1'b1; write = 1'b1; address = 8'h12; writedata = 8'h00;
                end
                if (beats == 8) begin
                    chipselect = 1'b1; write = 1'b1; address = 8'h00; writedata = 8'hFF;
                end
                beats++;
                if (tlast) seen_last = 1'b1;
            end
        end
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tvalid) extra++;
        end
        n_tests++;
        if (!seen_last || beats !== 13) begin
            n_fail++; $display("FAIL stop_complete: tlast=%0d beats=%0d want 1 13", seen_last, beats);
        end
        n_tests++;
        if (extra !== 0) begin n_fail++; $display("FAIL stop_idle: %0d valid cycles after tlast want 0", extra); end
        bus_read(8'h13, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL stop_status: got %h want 00", d); end
        bus_read(8'h00, d);
        n_tests++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL busy_write_ignored: got %h want 01", d); end
    endtask

    task automatic test_long_and_reset();
        logic [7:0] d;
        int  bad = 0;
        int  beats = 0;
        int  cyc = 0;
        bit  hit = 1'b0;
        bus_write(8'h12, 8'h04);
        bus_read(8'h13, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL clear_full: got %h want 00", d); end
        for (int i = 0; i < 64; i++) bus_write(8'h14, 8'(i + 1));
        bus_read(8'h13, d);
        n_tests++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL buffer_full: got %h want 02", d); end
        bus_write(8'h0E, 8'd100);
        bus_write(8'h0F, 8'd0);
        bus_write(8'h11, 8'd1);
        bus_write(8'h12, 8'h01);
        capture(1, 1'b0, 300);
        n_tests++;
        if (!cap_done || cap_data.size() !== 43 || cap_bytes.size() !== 86) begin
            n_fail++;
            $display("FAIL long_len: done=%0d beats=%0d bytes=%0d want 1 43 86", cap_done, cap_data.size(),
                     cap_bytes.size());
        end
        if (cap_bytes.size() == 86) for (int i = 0; i < 64; i++) if (cap_bytes[22 + i] !== 8'(i + 1)) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL long_payload: %0d bad bytes want 0", bad); end
        if (cap_data.size() == 43) begin
            n_tests++;
            if (cap_data[42] !== 16'h3F40 || cap_keep[42] !== 2'b11) begin
                n_fail++; $display("FAIL long_last: got %h/%b want 3F40/11", cap_data[42], cap_keep[42]);
            end
        end
        bus_read(8'h18, d);
        n_tests++;
        if (d !== 8'h20) begin n_fail++; $display("FAIL long_csum0: got %h want 20", d); end
        bus_read(8'h19, d);
        n_tests++;
        if (d !== 8'h08) begin n_fail++; $display("FAIL long_csum1: got %h want 08", d); end

        bus_write(8'h12, 8'h01);
        while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            tready = 1'b1;
            if (tvalid) begin
                if (beats == 5) begin
                    #1 reset = 1'b1;
                    #1;
                    hit = 1'b1;
                    n_tests++;
                    if (tvalid !== 1'b0 || tdata !== 16'h0 || tkeep !== 2'b00 || tlast !== 1'b0) begin
                        n_fail++;
                        $display("FAIL async_reset: tvalid=%b tdata=%h tkeep=%b want 0", tvalid, tdata, tkeep);
                    end
                end else begin
                    beats++;
                end
            end
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL reset_point: reached %0d beats want 5", beats); end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int a = 0; a < 8'h1C; a++) begin
            if (a == 8'h14 || (a > 8'h14 && a < 8'h18)) continue;
            bus_read(8'(a), d);
            if (d !== 8'h00) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_regs: %0d nonzero registers want 0", bad); end
        repeat (5) @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b0) begin n_fail++; $display("FAIL no_resume: tvalid=%b want 0", tvalid); end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) exp_hdr[i] = 8'hAA;
        exp_hdr[7] = 8'hAB;
        for (int i = 0; i < 12; i++) exp_hdr[8 + i] = 8'(i + 1);
        exp_hdr[20] = 8'h08;
        exp_hdr[21] = 8'h00;
        test_reset();
        test_buffer_frame();
        test_pattern();
        test_backpressure();
        test_stop_mid_frame();
        test_long_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
